// File: rtl/multdiv_pkg.sv
// ============================================================================
//  Module   : multdiv_pkg
//  Brief    : Shared types and constants for the iterative multiply/divide unit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of add/sub iterations per operation
    localparam int MD_ITER = 32;

    // Step-datapath operation codes: multiply adds, divide subtracts
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/multdiv_step.sv
// ============================================================================
//  Module   : multdiv_step
//  Brief    : Combinational add/sub step with carry (no-borrow) out, shared by
//             the multiply and divide iterations
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import multdiv_pkg::*;

module multdiv_step #(
    parameter int W = 33
) (
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] b_eff;

    // Subtraction is a + ~b + 1; carry out = 1 means no borrow
    assign b_eff        = (op == OP_DIV) ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, op};

endmodule

`default_nettype wire

// File: rtl/multdiv_ctrl.sv
// ============================================================================
//  Module   : multdiv_ctrl
//  Brief    : Iterative signed multiply/divide controller. Radix-2 shift-add
//             multiply and restoring divide on operand magnitudes, signs fixed
//             up on the final iteration. Optional feature macro:
//             MULTDIV_EARLY_EXIT_EN - multiply finishes as soon as the
//             remaining multiplier bits are all zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import multdiv_pkg::*;

module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi, lo, hi_n, lo_n;
    logic [WIDTH:0]     opnd, mag_a, mag_b;
    logic               sign;
    logic               start, div_zero, last_iter;
    logic               step_op, step_c;
    logic [WIDTH:0]     step_a, step_b, step_s;
    logic [2*WIDTH-1:0] prod_mag, prod_sgn;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_exc;
`ifdef MULTDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0]   mrem;
    logic [CW-1:0]      shamt;
`endif

    // Start decode; MULT has priority when both pulses coincide
    assign start    = ctrl_MULT | ctrl_DIV;
    assign div_zero = ~ctrl_MULT & (data_operandB == '0);
    // 33-bit magnitudes so that -2^31 is representable
    assign mag_a    = data_operandA[WIDTH-1] ? -{1'b1, data_operandA} : {1'b0, data_operandA};
    assign mag_b    = data_operandB[WIDTH-1] ? -{1'b1, data_operandB} : {1'b0, data_operandB};

    multdiv_step #(.W(WIDTH + 1)) u_step (
        .op    (step_op),
        .a     (step_a),
        .b     (step_b),
        .sum   (step_s),
        .carry (step_c)
    );

    // One iteration of the datapath plus the signed fix-up of the finished value
    always_comb begin
        step_op   = OP_MUL;
        step_a    = {1'b0, hi};
        step_b    = lo[0] ? opnd : '0;
        hi_n      = step_s[WIDTH:1];
        lo_n      = {step_s[0], lo[WIDTH-1:1]};
        last_iter = (count == LAST);
        if (state == ST_DIV) begin
            step_op = OP_DIV;
            step_a  = {hi, lo[WIDTH-1]};
            step_b  = opnd;
            hi_n    = step_c ? step_s[WIDTH-1:0] : step_a[WIDTH-1:0];
            lo_n    = {lo[WIDTH-2:0], step_c};
        end
        prod_mag = {hi_n, lo_n};
`ifdef MULTDIV_EARLY_EXIT_EN
        // Early finish leaves the product offset by the iterations skipped
        shamt    = LAST - count;
        prod_mag = prod_mag >> shamt;
        if (state == ST_MUL && mrem[WIDTH-1:1] == '0)
            last_iter = 1'b1;
`endif
        prod_sgn = (sign && (|prod_mag)) ? -prod_mag : prod_mag;
        if (state == ST_DIV) begin
            fin_res = sign ? -lo_n : lo_n;
            fin_exc = ~sign & lo_n[WIDTH-1];
        end else begin
            fin_res = prod_sgn[WIDTH-1:0];
            fin_exc = ~((&prod_sgn[2*WIDTH-1:WIDTH-1]) | ~(|prod_sgn[2*WIDTH-1:WIDTH-1]));
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state and ready decode; a start overrides whatever is running
    always_comb begin
        state_nx       = state;
        data_resultRDY = (state == ST_DONE);
        case (state)
            ST_IDLE:        state_nx = ST_IDLE;
            ST_MUL, ST_DIV: if (last_iter) state_nx = ST_DONE;
            ST_DONE:        state_nx = ST_IDLE;
            default:        state_nx = ST_IDLE;
        endcase
        if (start)
            state_nx = ctrl_MULT ? ST_MUL : (div_zero ? ST_DONE : ST_DIV);
    end

    // Operand latch, iteration registers and result capture
    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            hi             <= '0;
            lo             <= '0;
            opnd           <= '0;
            sign           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULTDIV_EARLY_EXIT_EN
            mrem           <= '0;
`endif
        end else if (start) begin
            count <= '0;
            hi    <= '0;
            sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (ctrl_MULT) begin
                opnd <= mag_a;
                lo   <= mag_b[WIDTH-1:0];
            end else begin
                opnd <= mag_b;
                lo   <= mag_a[WIDTH-1:0];
                if (div_zero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end
            end
`ifdef MULTDIV_EARLY_EXIT_EN
            mrem  <= mag_b[WIDTH-1:0];
`endif
        end else if (state == ST_MUL || state == ST_DIV) begin
            hi <= hi_n;
            lo <= lo_n;
            if (count != LAST) count <= count + 1'b1;
`ifdef MULTDIV_EARLY_EXIT_EN
            mrem <= mrem >> 1;
`endif
            if (last_iter) begin
                data_result    <= fin_res;
                data_exception <= fin_exc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
// ============================================================================
//  Module   : tb_multdiv_ctrl
//  Brief    : Self-checking bench for multdiv_ctrl: arithmetic reference model,
//             per-cycle compare, directed literal cases and random traffic
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Reference model state
    int          remain = 0;
    logic [31:0] pend_res = '0, shown_res = '0;
    logic        pend_exc = 1'b0, shown_exc = 1'b0;

`ifdef MULTDIV_EARLY_EXIT_EN
    localparam int          L_7X6 = 4;
    localparam int          L_SQ  = 18;
    localparam int          L_MIN = 2;
    localparam logic [31:0] T5_B  = 32'h4000_0000;
`else
    localparam int          L_7X6 = 33;
    localparam int          L_SQ  = 33;
    localparam int          L_MIN = 33;
    localparam logic [31:0] T5_B  = 32'd4;
`endif

    multdiv_ctrl #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Expected result, exception and start-to-ready latency from plain arithmetic
    function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
`ifdef MULTDIV_EARLY_EXIT_EN
        logic [31:0] mag;
        int          bl;
`endif
        if (m) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p != longint'($signed(r)));
            lat = 33;
`ifdef MULTDIV_EARLY_EXIT_EN
            mag = b[31] ? -b : b;
            bl  = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
            lat = ((bl == 0) ? 1 : bl) + 1;
`endif
        end else if (b == 32'd0) begin
            r = '0; e = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = a; e = 1'b1; lat = 33;
        end else begin
            r = $signed(a) / $signed(b); e = 1'b0; lat = 33;
        end
    endfunction

    // Model advance on each rising edge
    always @(posedge clock) begin
        logic [31:0] r;
        logic        e;
        int          l;
        if (reset) begin
            remain = 0; shown_res = '0; shown_exc = 1'b0;
        end else begin
            if (remain > 0) remain--;
            if (ctrl_MULT || ctrl_DIV) begin
                model(ctrl_MULT, data_operandA, data_operandB, r, e, l);
                pend_res = r; pend_exc = e; remain = l;
            end
            if (remain == 1) begin
                shown_res = pend_res; shown_exc = pend_exc;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clock) begin
        if (checking) begin
            tests += 3;
            if (data_resultRDY !== (remain == 1)) begin
                fails++;
                $display("FAIL rdy t=%0t got %b exp %b", $time, data_resultRDY, (remain == 1));
            end
            if (data_result !== shown_res) begin
                fails++;
                $display("FAIL result t=%0t got %h exp %h", $time, data_result, shown_res);
            end
            if (data_exception !== shown_exc) begin
                fails++;
                $display("FAIL exc t=%0t got %b exp %b", $time, data_exception, shown_exc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Start pulse in cycle 0, then report the first cycle with RDY (0 = none within 40)
    task automatic start_and_wait(input logic m, input logic [31:0] a, input logic [31:0] b,
                                  output int seen);
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = ~m; data_operandA = a; data_operandB = b;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) begin
                ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
                data_operandA = $urandom; data_operandB = $urandom;
            end
            if (data_resultRDY) begin seen = k; break; end
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] er,
                          input logic ee);
        int seen;
        start_and_wait(m, a, b, seen);
        check({name, "_lat"}, seen, lat);
        check({name, "_res"}, data_result, er);
        check({name, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 15);
            5:       return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        int sel;
        int gap;
        repeat (3) @(negedge clock);
        checking = 1'b1;
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_res", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        reset = 1'b0;

        run_op("mul_7x-6",   1'b1, 32'd7, -32'sd6, L_7X6, 32'hFFFF_FFD6, 1'b0);
        run_op("mul_ovf",    1'b1, 32'h0001_0000, 32'h0001_0000, L_SQ, 32'h0, 1'b1);
        run_op("mul_min",    1'b1, 32'h8000_0000, 32'd1, L_MIN, 32'h8000_0000, 1'b0);
        run_op("div_-7/2",   1'b0, -32'sd7, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
        run_op("div_zero",   1'b0, 32'd5, 32'd0, 1, 32'h0, 1'b1);
        run_op("div_ovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
`ifdef MULTDIV_EARLY_EXIT_EN
        run_op("mul_9x1_ee", 1'b1, 32'd9, 32'd1, 2, 32'd9, 1'b0);
`endif

        // Abort: MULT in cycle 0, DIV 100/7 in cycle 10
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = T5_B;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            if (data_resultRDY) seen = k;
        end
        check("abort_no_rdy", seen, 0);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (data_resultRDY) begin seen = k; break; end
        end
        check("abort_lat", seen, 33);
        check("abort_res", data_result, 32'd14);

        // Reset in cycle 15 of a long MULT
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'h7FFF_FFFF;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_mid_res", data_result, 32'd0);
        repeat (40) @(negedge clock);
        check("rst_mid_idle_rdy", {31'd0, data_resultRDY}, 32'd0);

        // Random traffic, including aborts, double starts and resets
        for (int i = 0; i < 250; i++) begin
            @(negedge clock);
            sel = $urandom_range(0, 9);
            ctrl_MULT = (sel < 5) || (sel == 9);
            ctrl_DIV  = (sel >= 5);
            data_operandA = pick();
            data_operandB = pick();
            @(negedge clock);
            ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
            data_operandA = $urandom; data_operandB = $urandom;
            gap = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 20) : $urandom_range(33, 38);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                reset = ($urandom_range(0, 299) == 0);
            end
            reset = 1'b0;
        end
        repeat (40) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
